// File: rtl/decode_pkg.sv
// Shared opcode constants, instruction field positions and decode helpers
// for the multi-issue decode stage.
package decode_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_BR  = 4'hD;

  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RD_LSB  = 9;
  localparam int unsigned RS1_LSB = 6;
  localparam int unsigned IMM_BIT = 5;
  localparam int unsigned RS2_LSB = 2;
  localparam int unsigned IMM_W   = 5;
  localparam int unsigned BOFF_W  = 12;

  function automatic logic writes_rd(input logic [3:0] op);
    return (op != OP_NOP) && (op != OP_BR);
  endfunction

endpackage

// File: rtl/decode_lane.sv
// Combinational single-instruction decoder: 16-bit instruction plus pc in,
// register fields, immediate and branch target out.
module decode_lane
  import decode_pkg::*;
#(
  parameter int unsigned XLEN = 16
) (
  input  logic [15:0]     instr,
  input  logic [XLEN-1:0] pc,
  output logic [3:0]      opcode,
  output logic [2:0]      rd,
  output logic [2:0]      rs1,
  output logic [2:0]      rs2,
  output logic            imm_flag,
  output logic [XLEN-1:0] imm_ext,
  output logic            is_branch,
  output logic [XLEN-1:0] branch_target
);

  always_comb begin
    opcode    = instr[OPC_LSB +: 4];
    rd        = instr[RD_LSB +: 3];
    rs1       = instr[RS1_LSB +: 3];
    imm_flag  = instr[IMM_BIT];
    rs2       = imm_flag ? 3'd0 : instr[RS2_LSB +: 3];
    imm_ext   = imm_flag ? {{(XLEN-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]} : '0;
    is_branch = (opcode == OP_BR);
    branch_target = is_branch ?
        pc + {{(XLEN-BOFF_W){instr[BOFF_W-1]}}, instr[BOFF_W-1:0]} : '0;
  end

endmodule

// File: rtl/decode_unit_mi.sv
// Multi-issue decode stage: buffers fetch bundles and issues up to LANES
// instructions per cycle, cutting the bundle at RAW hazards and after branches.
module decode_unit_mi
  import decode_pkg::*;
#(
  parameter int unsigned LANES     = 2,
  parameter int unsigned BUF_DEPTH = 4,
  parameter int unsigned XLEN      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  is_branch_taken,
  input  logic [LANES-1:0]      in_valid,
  output logic                  in_ready,
  input  logic [LANES*16-1:0]   instr_in,
  input  logic [LANES*XLEN-1:0] pc_in,
  output logic [LANES-1:0]      out_valid,
  output logic [LANES*4-1:0]    opcode,
  output logic [LANES*3-1:0]    rd,
  output logic [LANES*3-1:0]    rs1,
  output logic [LANES*3-1:0]    rs2,
  output logic [LANES-1:0]      imm_flag,
  output logic [LANES*XLEN-1:0] imm_ext,
  output logic [LANES-1:0]      is_branch,
  output logic [LANES*XLEN-1:0] branch_target
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  logic [15:0]      ibuf_instr [BUF_DEPTH];
  logic [XLEN-1:0]  ibuf_pc    [BUF_DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] push_n, issue_n;
  logic             push;

  logic [PTR_W-1:0] rd_idx [LANES];
  logic [PTR_W-1:0] wr_idx [LANES];
  logic [3:0]       d_op   [LANES];
  logic [2:0]       d_rd   [LANES];
  logic [2:0]       d_rs1  [LANES];
  logic [2:0]       d_rs2  [LANES];
  logic             d_imm  [LANES];
  logic [XLEN-1:0]  d_immx [LANES];
  logic             d_br   [LANES];
  logic [XLEN-1:0]  d_bt   [LANES];

  logic [LANES-1:0]      out_valid_d, imm_flag_d, is_branch_d;
  logic [LANES*4-1:0]    opcode_d;
  logic [LANES*3-1:0]    rd_d, rs1_d, rs2_d;
  logic [LANES*XLEN-1:0] imm_ext_d, branch_target_d;

  assign in_ready = (BUF_DEPTH - 32'(count_q)) >= LANES;
  assign push     = (|in_valid) && in_ready && !is_branch_taken;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign rd_idx[g] = head_q + PTR_W'(g);
    assign wr_idx[g] = tail_q + PTR_W'(g);

    decode_lane #(.XLEN(XLEN)) u_lane (
      .instr        (ibuf_instr[rd_idx[g]]),
      .pc           (ibuf_pc[rd_idx[g]]),
      .opcode       (d_op[g]),
      .rd           (d_rd[g]),
      .rs1          (d_rs1[g]),
      .rs2          (d_rs2[g]),
      .imm_flag     (d_imm[g]),
      .imm_ext      (d_immx[g]),
      .is_branch    (d_br[g]),
      .branch_target(d_bt[g])
    );
  end

  // Only the contiguous run of valid lanes starting at lane 0 is accepted.
  always_comb begin
    logic gap;
    push_n = '0;
    gap    = 1'b0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (!in_valid[i]) gap = 1'b1;
      else if (!gap) push_n = push_n + CNT_W'(1);
    end
  end

  always_comb begin
    logic stop, prev_br, hazard;
    issue_n = '0;
    stop    = 1'b0;
    prev_br = 1'b0;
    for (int j = 0; j < int'(LANES); j++) begin
      hazard = prev_br;
      for (int i = 0; i < j; i++) begin
        if (writes_rd(d_op[i]) &&
            (d_rd[i] == d_rs1[j] || (!d_imm[j] && d_rd[i] == d_rs2[j]))) hazard = 1'b1;
      end
      if (!stop && !hazard && j < int'(count_q)) issue_n = issue_n + CNT_W'(1);
      else stop = 1'b1;
      prev_br = d_br[j];
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (is_branch_taken) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push)   tail_d = tail_q + PTR_W'(push_n);
      if (!stall) head_d = head_q + PTR_W'(issue_n);
      count_d = count_q + (push ? push_n : '0) - (stall ? '0 : issue_n);
    end
  end

  always_comb begin
    out_valid_d     = out_valid;
    opcode_d        = opcode;
    rd_d            = rd;
    rs1_d           = rs1;
    rs2_d           = rs2;
    imm_flag_d      = imm_flag;
    imm_ext_d       = imm_ext;
    is_branch_d     = is_branch;
    branch_target_d = branch_target;
    if (is_branch_taken || !stall) begin
      out_valid_d     = '0;
      opcode_d        = '0;
      rd_d            = '0;
      rs1_d           = '0;
      rs2_d           = '0;
      imm_flag_d      = '0;
      imm_ext_d       = '0;
      is_branch_d     = '0;
      branch_target_d = '0;
      if (!is_branch_taken) begin
        for (int j = 0; j < int'(LANES); j++) begin
          if (j < int'(issue_n)) begin
            out_valid_d[j]                 = 1'b1;
            opcode_d[j*4 +: 4]             = d_op[j];
            rd_d[j*3 +: 3]                 = d_rd[j];
            rs1_d[j*3 +: 3]                = d_rs1[j];
            rs2_d[j*3 +: 3]                = d_rs2[j];
            imm_flag_d[j]                  = d_imm[j];
            imm_ext_d[j*XLEN +: XLEN]      = d_immx[j];
            is_branch_d[j]                 = d_br[j];
            branch_target_d[j*XLEN +: XLEN] = d_bt[j];
          end
        end
      end
    end
  end

  // Buffer storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (i < int'(push_n)) begin
          ibuf_instr[wr_idx[i]] <= instr_in[i*16 +: 16];
          ibuf_pc[wr_idx[i]]    <= pc_in[i*XLEN +: XLEN];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      out_valid     <= '0;
      opcode        <= '0;
      rd            <= '0;
      rs1           <= '0;
      rs2           <= '0;
      imm_flag      <= '0;
      imm_ext       <= '0;
      is_branch     <= '0;
      branch_target <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      out_valid     <= out_valid_d;
      opcode        <= opcode_d;
      rd            <= rd_d;
      rs1           <= rs1_d;
      rs2           <= rs2_d;
      imm_flag      <= imm_flag_d;
      imm_ext       <= imm_ext_d;
      is_branch     <= is_branch_d;
      branch_target <= branch_target_d;
    end
  end

endmodule
